// File: rtl/freq_meter_pkg.sv
// Shared types and default widths for the frequency meter blocks.
package freq_meter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GATE,
        CAPTURE,
        VALID,
        HOLD
    } gate_state_t;

    localparam int GATE_W_DEF = 27;
    localparam int CNT_W_DEF  = 16;

endpackage

// File: rtl/meas_gate_ctrl.sv
// Measurement-window controller: drives the edge-counter gate, captures the
// settled count and hands it downstream over valid/ready.
module meas_gate_ctrl
    import freq_meter_pkg::*;
#(
    parameter int GATE_W  = GATE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int HOLDOFF = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [CNT_W-1:0]  counter_in,
    output logic              enable,
    output logic [CNT_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy
);

    localparam logic [GATE_W-1:0] ONE       = GATE_W'(1);
    localparam logic [GATE_W-1:0] HOLD_LOAD = GATE_W'(HOLDOFF);

    gate_state_t       state, state_nx;
    logic [GATE_W-1:0] cnt, cnt_nx;

    // One down-counter serves both the gate window and the holdoff gap.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (start || cont) begin
                    state_nx = GATE;
                    cnt_nx   = (gate_len == '0) ? ONE : gate_len;
                end
            end
            GATE: begin
                if (cnt == ONE) state_nx = CAPTURE;
                else            cnt_nx   = cnt - ONE;
            end
            CAPTURE: state_nx = VALID;
            VALID: begin
                if (result_ready) begin
                    if (HOLDOFF == 0) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = HOLD;
                        cnt_nx   = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                if (cnt <= ONE) state_nx = IDLE;
                else            cnt_nx   = cnt - ONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            enable       <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            enable <= (state_nx == GATE);
            busy   <= (state_nx != IDLE);
            if (state == CAPTURE) begin
                result       <= counter_in;
                result_valid <= 1'b1;
            end else if (state == VALID && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_meas_gate_ctrl.sv
// Bench for meas_gate_ctrl: edge-counter model, per-window timeline reference.
module tb_meas_gate_ctrl;

    localparam int GW = 27;
    localparam int CW = 16;
    localparam int HO = 2;

    logic          clk = 1'b0;
    logic          rst, start, cont, result_ready, inc;
    logic [GW-1:0] gate_len;
    logic [CW-1:0] counter_in, result;
    logic          enable, result_valid, busy;

    meas_gate_ctrl #(.GATE_W(GW), .CNT_W(CW), .HOLDOFF(HO)) dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .gate_len(gate_len),
        .counter_in(counter_in), .enable(enable), .result(result),
        .result_valid(result_valid), .result_ready(result_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    // Edge counter: clears on the first gate cycle, counts inc afterwards.
    logic          en_d = 1'b0;
    logic [CW-1:0] ecnt = '0;
    always @(posedge clk) begin
        en_d <= enable;
        if (enable && !en_d)     ecnt <= '0;
        else if (enable && inc)  ecnt <= ecnt + CW'(1);
    end
    assign counter_in = ecnt;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic pick_inc(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return 1'($urandom);
    endfunction

    // One single-shot window starting from IDLE; expected waveforms come from
    // the window timeline: gate 1..L, valid L+2..handshake, holdoff after.
    task automatic run_win(input int len, input int inc_mode, input int dly,
                           input bit noise, input bit use_exp, input int exp_res);
        int le, vstart, hs, bend, sum;
        le     = (len == 0) ? 1 : len;
        vstart = le + 2;
        hs     = vstart + dly;
        bend   = hs + HO;
        sum    = 0;
        start        = 1'b1;
        cont         = 1'b0;
        gate_len     = GW'(len);
        result_ready = 1'b0;
        inc          = pick_inc(inc_mode);
        tick();
        for (int t = 1; t <= bend + 2; t++) begin
            chk("enable", int'(enable), int'(t <= le));
            chk("busy", int'(busy), int'(t <= bend));
            chk("result_valid", int'(result_valid), int'(t >= vstart && t <= hs));
            if (t >= vstart && t <= hs)
                chk("result", int'(result), use_exp ? exp_res : (sum % (1 << CW)));
            inc = pick_inc(inc_mode);
            if (t >= 2 && t <= le && inc) sum++;
            start = (noise && t <= bend) ? 1'($urandom) : 1'b0;
            if (noise) gate_len = GW'($urandom_range(0, 40));
            result_ready = (t >= hs) || (noise && t < vstart && 1'($urandom));
            tick();
        end
        start = 1'b0;
        result_ready = 1'b0;
    endtask

    typedef struct {
        int len;
        int inc_mode;
        int dly;
        bit noise;
        int exp_res;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int rises[$];
        int prev_en, waited;

        tbl[0] = '{10, 1, 0,  0, 9};
        tbl[1] = '{0,  1, 0,  0, 0};
        tbl[2] = '{1,  1, 0,  0, 0};
        tbl[3] = '{2,  1, 0,  0, 1};
        tbl[4] = '{10, 1, 20, 1, 9};
        tbl[5] = '{3,  1, 0,  0, 2};
        tbl[6] = '{7,  0, 3,  0, 0};
        tbl[7] = '{12, 1, 1,  1, 11};

        rst = 1'b1; start = 1'b0; cont = 1'b0; gate_len = '0;
        result_ready = 1'b0; inc = 1'b0;
        repeat (3) tick();
        chk("rst_enable", int'(enable), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(result_valid), 0);
        chk("rst_result", int'(result), 0);
        rst = 1'b0;
        tick();

        foreach (tbl[i])
            run_win(tbl[i].len, tbl[i].inc_mode, tbl[i].dly, tbl[i].noise, 1'b1, tbl[i].exp_res);

        for (int k = 0; k < 30; k++)
            run_win($urandom_range(0, 20), 2, $urandom_range(0, 5), 1'($urandom), 1'b0, 0);

        // Reset in cycle 3 of a 10-cycle window
        start = 1'b1; gate_len = GW'(10); inc = 1'b1; result_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_enable", int'(enable), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_enable", int'(enable), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_result", int'(result), 0);
        for (int t = 0; t < 20; t++) begin
            chk("post_rst_valid", int'(result_valid), 0);
            chk("post_rst_busy", int'(busy), 0);
            tick();
        end

        // Continuous mode: rising gate edges every gate_len+3+HOLDOFF cycles
        cont = 1'b1; gate_len = GW'(5); result_ready = 1'b1; inc = 1'b1;
        prev_en = 0;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (enable && prev_en == 0) rises.push_back(t);
            if (result_valid) chk("cont_result", int'(result), 4);
            prev_en = int'(enable);
        end
        chk("cont_rise_count_ok", int'(rises.size() >= 4), 1);
        for (int i = 1; i < rises.size(); i++)
            chk("cont_period", rises[i] - rises[i-1], 5 + 3 + HO);
        cont = 1'b0;
        waited = 0;
        while (busy && waited < 40) begin
            tick();
            waited++;
        end
        chk("cont_stop_idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
